// File: rtl/blood_type_encoder_pkg.sv
// Shared definitions for the blood_type encoder and classifier.
// Optional feature macro: BLOOD_PARITY_CHECK_EN (adds the GET_PAR state).
package blood_pkg;

    // FSM state encoding; GET_PAR only exists when the parity beat is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        GET_RH = 3'd3,
`ifdef BLOOD_PARITY_CHECK_EN
        GET_PAR = 3'd4,
`endif
        OUT    = 3'd5
    } state_t;

    // Bit positions of each antigen inside the 3-bit code.
    localparam int BT_A  = 2;
    localparam int BT_B  = 1;
    localparam int BT_RH = 0;

    // Named blood_type codes.
    localparam logic [2:0] O_NEG  = 3'b000;
    localparam logic [2:0] O_POS  = 3'b001;
    localparam logic [2:0] B_NEG  = 3'b010;
    localparam logic [2:0] B_POS  = 3'b011;
    localparam logic [2:0] A_NEG  = 3'b100;
    localparam logic [2:0] A_POS  = 3'b101;
    localparam logic [2:0] AB_NEG = 3'b110;
    localparam logic [2:0] AB_POS = 3'b111;

    // Even parity over {A, B, Rh, par}: a good sample has an even number of ones.
    function automatic logic even_parity_ok(input logic [2:0] code, input logic par);
        return (^{code, par}) == 1'b0;
    endfunction

endpackage

// File: rtl/blood_beat_timer.sv
// Per-beat timeout counter. Clear reloads zero, enable counts up and
// saturates at TIMEOUT-1, where expire is raised.
module blood_beat_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Count idle cycles; saturating so expire stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == LAST);

endmodule

// File: rtl/blood_type_encoder.sv
// Assembles three serial antigen results (A, B, Rh) into a 3-bit blood_type
// code and offers it on a valid/ready handshake.
// Optional feature macro: BLOOD_PARITY_CHECK_EN adds a fourth even-parity
// beat; a failing parity drops the code and pulses err.
//
// Handshakes: on the input side a beat is taken in any GET_* state on a
// cycle with test_valid=1 (test_ready=1 there); on the output side a
// transfer happens on any cycle with type_valid=1 and type_ready=1, and
// type_valid/blood_type stay stable until that cycle.
module blood_type_encoder
    import blood_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_start,
    input  logic             test_valid,
    input  logic             test_bit,
    output logic             test_ready,
    output logic [2:0]       blood_type,
    output logic             type_valid,
    input  logic             type_ready,
    output logic             err,
    output logic [CNT_W-1:0] sample_count,
    output state_t           state_dbg
);

    state_t           state_q, state_d;
    logic [2:0]       asm_q, asm_d;
    logic [2:0]       bt_q, bt_d;
    logic             tv_q, tv_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_get;
    logic             tmr_clear, tmr_en, tmr_expire;

    blood_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    // State and output registers; reset discards everything without err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            asm_q   <= '0;
            bt_q    <= '0;
            tv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            bt_q    <= bt_d;
            tv_q    <= tv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: aborts (restart, timeout) first, then beat capture.
    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        bt_d      = bt_q;
        tv_d      = tv_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        tmr_clear = 1'b1;
        tmr_en    = 1'b0;

        in_get = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_RH)
`ifdef BLOOD_PARITY_CHECK_EN
              || (state_q == GET_PAR)
`endif
              ;

        if (in_get) begin
            if (sample_start) begin
                // Restart wins over a coincident beat.
                err_d   = 1'b1;
                state_d = GET_A;
                asm_d   = '0;
            end else if (!test_valid) begin
                if (tmr_expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_clear = 1'b0;
                    tmr_en    = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (sample_start) begin
                    state_d = GET_A;
                    asm_d   = '0;
                end
            end
            GET_A: begin
                if (test_valid && !sample_start) begin
                    asm_d[BT_A] = test_bit;
                    state_d     = GET_B;
                end
            end
            GET_B: begin
                if (test_valid && !sample_start) begin
                    asm_d[BT_B] = test_bit;
                    state_d     = GET_RH;
                end
            end
            GET_RH: begin
                if (test_valid && !sample_start) begin
                    asm_d[BT_RH] = test_bit;
`ifdef BLOOD_PARITY_CHECK_EN
                    state_d      = GET_PAR;
`else
                    bt_d         = asm_d;
                    tv_d         = 1'b1;
                    state_d      = OUT;
`endif
                end
            end
`ifdef BLOOD_PARITY_CHECK_EN
            GET_PAR: begin
                if (test_valid && !sample_start) begin
                    if (even_parity_ok(asm_q, test_bit)) begin
                        bt_d    = asm_q;
                        tv_d    = 1'b1;
                        state_d = OUT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            OUT: begin
                // type_valid is always high here, so ready alone completes the transfer.
                if (type_ready) begin
                    tv_d    = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign test_ready   = (state_q != OUT);
    assign blood_type   = bt_q;
    assign type_valid   = tv_q;
    assign err          = err_q;
    assign sample_count = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_blood_type_encoder.sv
// Directed bench for blood_type_encoder: a vector table of codes plus
// hand-written sequences for backpressure, timeout, restart, reset and parity.
module tb_blood_type_encoder;
    import blood_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_start = 1'b0;
    logic             test_valid = 1'b0;
    logic             test_bit = 1'b0;
    logic             type_ready = 1'b0;
    logic             test_ready;
    logic [2:0]       blood_type;
    logic             type_valid;
    logic             err;
    logic [CNT_W-1:0] sample_count;
    state_t           state_dbg;

    blood_type_encoder #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_start (sample_start),
        .test_valid   (test_valid),
        .test_bit     (test_bit),
        .test_ready   (test_ready),
        .blood_type   (blood_type),
        .type_valid   (type_valid),
        .type_ready   (type_ready),
        .err          (err),
        .sample_count (sample_count),
        .state_dbg    (state_dbg)
    );

    // Clock and run-time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int               n_cmp = 0;
    int               n_bad = 0;
    int               err_cnt = 0;
    logic [2:0]       exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    typedef struct {
        logic       a;
        logic       b;
        logic       rh;
        int         stall;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    // Count err pulses between clock edges.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sample();
        sample_start = 1'b1;
        step();
        sample_start = 1'b0;
    endtask

    // Three antigen beats, plus the even-parity beat when that feature is built in.
    task automatic send_beats(input logic [2:0] code);
        test_valid = 1'b1;
        test_bit = code[2];
        step();
        test_bit = code[1];
        step();
        test_bit = code[0];
        step();
`ifdef BLOOD_PARITY_CHECK_EN
        test_bit = ^code;
        step();
`endif
        test_valid = 1'b0;
        test_bit = 1'b0;
    endtask

    // Checks after the last beat: latency, hold under backpressure, one transfer.
    task automatic finish_delivery(input string tag, input logic [2:0] exp_code, input int stall);
        exp_q.push_back(exp_code);
        check({tag, "_valid_rise"}, {31'd0, type_valid}, 32'd1);
        check({tag, "_code"}, {29'd0, blood_type}, {29'd0, exp_q[0]});
        check({tag, "_test_ready_out"}, {31'd0, test_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            type_ready = 1'b0;
            sample_start = (i == 2);
            test_valid = (i == 3);
            test_bit = 1'b1;
            step();
            check({tag, "_hold"}, {28'd0, type_valid, blood_type}, {28'd0, 1'b1, exp_q[0]});
        end
        sample_start = 1'b0;
        test_valid = 1'b0;
        test_bit = 1'b0;
        type_ready = 1'b1;
        step();
        type_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        check({tag, "_valid_drop"}, {31'd0, type_valid}, 32'd0);
        check({tag, "_count"}, {30'd0, sample_count}, {30'd0, exp_cnt});
        check({tag, "_code_kept"}, {29'd0, blood_type}, {29'd0, exp_q.pop_front()});
        check({tag, "_state_idle"}, {29'd0, state_dbg}, {29'd0, IDLE});
        step();
        check({tag, "_one_transfer"}, {30'd0, sample_count}, {30'd0, exp_cnt});
    endtask

    task automatic deliver(input string tag, input logic [2:0] bits, input logic [2:0] exp_code,
                           input int stall);
        int err0;
        err0 = err_cnt;
        start_sample();
        send_beats(bits);
        finish_delivery(tag, exp_code, stall);
        check({tag, "_no_err"}, err_cnt, err0);
    endtask

    // Main sequence and final report.
    initial begin
        int err0;

        vecs[0] = '{a: 1'b0, b: 1'b0, rh: 1'b0, stall: 0, exp_code: O_NEG};
        vecs[1] = '{a: 1'b0, b: 1'b0, rh: 1'b1, stall: 3, exp_code: O_POS};
        vecs[2] = '{a: 1'b0, b: 1'b1, rh: 1'b0, stall: 0, exp_code: B_NEG};
        vecs[3] = '{a: 1'b0, b: 1'b1, rh: 1'b1, stall: 1, exp_code: B_POS};
        vecs[4] = '{a: 1'b1, b: 1'b0, rh: 1'b0, stall: 0, exp_code: A_NEG};
        vecs[5] = '{a: 1'b1, b: 1'b0, rh: 1'b1, stall: 2, exp_code: A_POS};
        vecs[6] = '{a: 1'b1, b: 1'b1, rh: 1'b0, stall: 0, exp_code: AB_NEG};
        vecs[7] = '{a: 1'b1, b: 1'b1, rh: 1'b1, stall: 5, exp_code: AB_POS};

        // Reset values.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
        check("rst_test_ready", {31'd0, test_ready}, 32'd1);
        check("rst_outputs", {26'd0, blood_type, type_valid, err, sample_count}, 32'd0);
        check("rst_no_err", err_cnt, 0);

        // IDLE ignores beats.
        test_valid = 1'b1;
        test_bit = 1'b1;
        step();
        step();
        test_valid = 1'b0;
        check("idle_ignores_beat", {29'd0, state_dbg}, {29'd0, IDLE});

        // Basic delivery and backpressure.
        deliver("basic", 3'b101, A_POS, 0);
        deliver("backpressure", 3'b110, AB_NEG, 10);

        // Reset in GET_B clears everything with no err.
        err0 = err_cnt;
        start_sample();
        test_valid = 1'b1;
        test_bit = 1'b1;
        step();
        test_valid = 1'b0;
        check("midrst_in_get_b", {29'd0, state_dbg}, {29'd0, GET_B});
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        check("midrst_state", {29'd0, state_dbg}, {29'd0, IDLE});
        check("midrst_outputs", {26'd0, blood_type, type_valid, err, sample_count}, 32'd0);
        check("midrst_test_ready", {31'd0, test_ready}, 32'd1);
        step();
        check("midrst_no_err", err_cnt, err0);

        // Vector table: all eight codes; count wraps 1,2,3,0,1,2,3,0.
        for (int i = 0; i < 8; i++) begin
            deliver($sformatf("vec%0d", i), {vecs[i].a, vecs[i].b, vecs[i].rh},
                    vecs[i].exp_code, vecs[i].stall);
        end

        // Timeout: beat A, then four idle cycles in GET_B.
        err0 = err_cnt;
        start_sample();
        test_valid = 1'b1;
        test_bit = 1'b1;
        step();
        test_valid = 1'b0;
        step();
        step();
        step();
        check("tmo_not_yet", {30'd0, err, type_valid}, 32'd0);
        check("tmo_still_get_b", {29'd0, state_dbg}, {29'd0, GET_B});
        step();
        check("tmo_err", {30'd0, err, type_valid}, 32'b10);
        check("tmo_state", {29'd0, state_dbg}, {29'd0, IDLE});
        step();
        check("tmo_err_single", {31'd0, err}, 32'd0);
        check("tmo_err_count", err_cnt, err0 + 1);
        check("tmo_count_kept", {30'd0, sample_count}, {30'd0, exp_cnt});
        check("tmo_no_valid", {31'd0, type_valid}, 32'd0);

        // Restart with a coincident beat; the beat is dropped.
        err0 = err_cnt;
        start_sample();
        test_valid = 1'b1;
        test_bit = 1'b1;
        step();
        sample_start = 1'b1;
        test_valid = 1'b1;
        test_bit = 1'b1;
        step();
        sample_start = 1'b0;
        test_valid = 1'b0;
        check("restart_err", {31'd0, err}, 32'd1);
        check("restart_state", {29'd0, state_dbg}, {29'd0, GET_A});
        send_beats(3'b000);
        finish_delivery("restart", O_NEG, 0);
        check("restart_err_count", err_cnt, err0 + 1);

`ifdef BLOOD_PARITY_CHECK_EN
        // Parity: 0,1,1 with parity 1 is odd -> dropped.
        err0 = err_cnt;
        start_sample();
        test_valid = 1'b1;
        test_bit = 1'b0;
        step();
        test_bit = 1'b1;
        step();
        step();
        step();
        test_valid = 1'b0;
        test_bit = 1'b0;
        check("par_bad_err", {30'd0, err, type_valid}, 32'b10);
        check("par_bad_state", {29'd0, state_dbg}, {29'd0, IDLE});
        step();
        check("par_bad_no_valid", {31'd0, type_valid}, 32'd0);
        check("par_bad_err_count", err_cnt, err0 + 1);
        check("par_bad_code_kept", {29'd0, blood_type}, {29'd0, O_NEG});
        deliver("par_good", 3'b011, B_POS, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blood_type_encoder.md
Name: blood_type_encoder

Overview:
- Producer end of the 3-bit blood_type code consumed by the blood type classifier.
- Collects three serial antigen test results (A, B, Rh) from the sample-reader front end and assembles them into one blood_type code.
- Presents the code on a valid/ready handshake and holds it until the classifier side accepts it.
- Includes a per-beat timeout, abort/restart handling and a delivered-sample counter.

Parameters:
- TIMEOUT, 16: maximum cycles allowed between sample_start and each following test beat before the sample is aborted. Legal range is 2 to 2^16-1.
- CNT_W, 8: width of the delivered-sample counter.

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous, active-high reset
- sample_start  input  1  one-cycle pulse that begins a new sample
- test_valid  input  1  a test result beat is present on test_bit
- test_bit  input  1  test result: 1 = antigen present
- test_ready  output  1  block can accept sample_start or test beats
- blood_type  output  3  assembled code: bit2 = A antigen, bit1 = B antigen, bit0 = Rh+
- type_valid  output  1  blood_type holds a complete code
- type_ready  input  1  downstream accepts the code
- err  output  1  one-cycle pulse on abort (timeout, restart, or parity failure)
- sample_count  output  CNT_W  number of codes delivered; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE, blood_type = 3'b000, type_valid = 0, err = 0, sample_count = 0, test_ready = 1, timeout counter = 0.
- Reset applied mid-sample or while type_valid is high discards everything, with no err pulse.
- States: IDLE, GET_A, GET_B, GET_RH, (GET_PAR, only when the optional feature is enabled), OUT.
- test_ready is 1 in IDLE and in every GET_* state, and 0 in OUT.
- IDLE:
  - sample_start goes to GET_A.
  - test_valid is ignored.
- GET_A / GET_B / GET_RH:
  - A beat is accepted when test_valid = 1.
  - The accepted bit is shifted into the assembly register (GET_A → bit2, GET_B → bit1, GET_RH → bit0), and the FSM advances to the next state.
  - The timeout counter clears on each accepted beat and increments otherwise.
- Timeout:
  - When the counter reaches TIMEOUT-1 with no beat accepted in that cycle, pulse err and go to IDLE.
  - blood_type is not updated.
- Restart:
  - sample_start in any GET_* state pulses err and goes to GET_A.
  - The counter clears and the partial code is discarded.
  - If sample_start and test_valid occur in the same cycle, sample_start wins and the beat is dropped.
- Latency: the cycle after the Rh beat is accepted (or the parity beat, when enabled), blood_type is loaded with the code and type_valid = 1. State becomes OUT.
- OUT:
  - blood_type and type_valid are held stable while type_ready = 0.
  - sample_start and test_valid are ignored (test_ready = 0).
  - No timeout applies in OUT.
- Handshake:
  - A transfer occurs on any cycle with type_valid and type_ready both 1.
  - The next cycle: type_valid = 0, sample_count increments by 1 (wrapping from 2^CNT_W-1 to 0), and the state returns to IDLE.
  - blood_type keeps its last value after the transfer.
  - type_ready asserted outside OUT has no effect.
- err is a registered, single-cycle pulse. It never coincides with type_valid rising.

Optional Feature:
- Macro: BLOOD_PARITY_CHECK_EN.
- When defined:
  - A fourth state, GET_PAR, follows GET_RH. Its beat carries even parity over {A, B, Rh}.
  - If A^B^Rh^par = 0, the code is delivered as normal.
  - Otherwise err pulses, the code is dropped, and the FSM returns to IDLE.
  - GET_PAR is subject to the same timeout and restart rules as the other GET_* states.
- When undefined: GET_PAR and the parity logic are absent, and the FSM goes directly from GET_RH to OUT.

Decomposition:
- Shared package blood_pkg:
  - State encoding enum for the FSM.
  - Bit-position constants BT_A = 2, BT_B = 1, BT_RH = 0.
  - Named codes O_NEG = 3'b000, O_POS = 3'b001, B_NEG = 3'b010, B_POS = 3'b011, A_NEG = 3'b100, A_POS = 3'b101, AB_NEG = 3'b110, AB_POS = 3'b111.
  - The package is shared with the classifier.
- One sub-module, blood_beat_timer: a loadable timeout counter with clear, enable and expire outputs, parameterised by TIMEOUT.

Test Plan:
- Basic delivery: reset; sample_start; beats 1, 0, 1 on consecutive cycles with type_ready = 1 → blood_type = 3'b101 (A_POS) and type_valid high one cycle after the third beat; sample_count = 1.
- Backpressure: beats 1, 1, 0 with type_ready = 0 for 10 cycles → blood_type = 3'b110 held stable with type_valid high and test_ready = 0; extra sample_start/test_valid are ignored; raising type_ready gives exactly one transfer.
- Timeout: TIMEOUT = 4; sample_start; beat 1, then 4 idle cycles → err pulses once, state is IDLE, type_valid never asserts, sample_count unchanged.
- Restart: sample_start, beat 1, then sample_start together with test_valid, then beats 0, 0, 0 → one err pulse, delivered code = 3'b000.
- Counter wrap and reset: CNT_W = 2; deliver 4 samples → sample_count reads 1, 2, 3, 0; asserting rst in GET_B → all outputs return to reset values with no err.
- Parity (BLOOD_PARITY_CHECK_EN defined): beats 0, 1, 1 with parity 0 → code 3'b011 delivered; beats 0, 1, 1 with parity 1 → err pulse and no type_valid.
